// File: rtl/count_mon_pkg.sv
// count_mon_pkg
// Declarations shared by the counter monitor: the tracking FSM state type,
// the fixed segment patterns, and the hex-to-7-segment lookup.
// Segment bit order is {g,f,e,d,c,b,a}, and a 1 lights the segment.
package count_mon_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,   // next sample seeds prev_q/prev_dir and is not checked
        TRACK = 2'd1,   // every sample is checked against the expected step
        FAULT = 2'd2    // an illegal step was seen; wait for clear_fault
    } mon_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Glyphs 0-9, A, b, C, d, E, F
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_HEX[hex];
    endfunction

endpackage

// File: rtl/count_monitor_seg7_decode.sv
// seg7_decode
// Combinational hex-to-7-segment decoder. It has no register. The caller
// registers the result so it can override it, for example with the fault dash.
// Ports:
//   hex  in  4  nibble to display
//   seg  out 7  segments {g,f,e,d,c,b,a}, active high
module seg7_decode
    import count_mon_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/count_monitor.sv
// count_monitor
// Watches the output of an up/down counter that runs on the same clock. On
// every edge it checks that the new value is exactly one step from the
// previous one, in the direction sampled together with that previous value.
// It pulses on wrap-around, keeps a signed saturating net lap count, and
// drives a registered 7-segment image of the current count. An illegal step
// sets a sticky error and parks the monitor in FAULT until clear_fault.
// Ports:
//   clk          in   1      rising-edge clock, shared with the counter
//   rst          in   1      synchronous, active-high reset
//   q_in         in   CNT_W  counter value
//   up_down      in   1      counter direction (1 = up), same net the counter uses
//   clear_fault  in   1      leaves FAULT; ignored in other states
//   wrap_up      out  1      one-cycle pulse after a max->0 step while counting up
//   wrap_down    out  1      one-cycle pulse after a 0->max step while counting down
//   laps         out  LAP_W  signed net lap count, saturating
//   step_err     out  1      sticky illegal-step flag
//   seg          out  7      registered segments {g,f,e,d,c,b,a}, active high
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W = 3,    // legal range is 2..4
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] q_in,
    input  logic             up_down,
    input  logic             clear_fault,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic [LAP_W-1:0] laps,
    output logic             step_err,
    output logic [6:0]       seg
);

    localparam logic [CNT_W-1:0] Q_ZERO  = '0;
    localparam logic [CNT_W-1:0] Q_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] Q_MAX   = '1;
    localparam logic [LAP_W-1:0] LAP_ONE = {{(LAP_W-1){1'b0}}, 1'b1};
    // Two's-complement limits of the lap counter: 0111..1 and 1000..0
    localparam logic [LAP_W-1:0] LAP_MAX = {1'b0, {(LAP_W-1){1'b1}}};
    localparam logic [LAP_W-1:0] LAP_MIN = {1'b1, {(LAP_W-1){1'b0}}};

    mon_state_t       state;
    logic [CNT_W-1:0] prev_q;
    logic             prev_dir;

    logic [CNT_W-1:0] exp_q;
    logic             step_ok;
    logic             is_wrap_up;
    logic             is_wrap_down;
    logic [3:0]       hex;
    logic [6:0]       seg_dec;

    // The counter's next value follows the direction it saw on the same edge
    // as prev_q. A reversal therefore appears as a legal step back, not an error.
    // The add and subtract wrap naturally in CNT_W bits.
    assign exp_q   = prev_dir ? (prev_q + Q_ONE) : (prev_q - Q_ONE);
    assign step_ok = (q_in == exp_q);

    // These are only used when step_ok holds. The direction term keeps a
    // legal down step from 1 to 0 from looking like an up wrap, and the
    // same for the down case.
    assign is_wrap_up   =  prev_dir && (prev_q == Q_MAX)  && (q_in == Q_ZERO);
    assign is_wrap_down = !prev_dir && (prev_q == Q_ZERO) && (q_in == Q_MAX);

    // Zero-extend the count to a nibble. A per-bit copy still works when
    // CNT_W is 4, where a replication count of zero would be illegal.
    always_comb begin
        hex = 4'h0;
        hex[CNT_W-1:0] = q_in;
    end

    seg7_decode u_seg7 (
        .hex (hex),
        .seg (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            prev_q    <= Q_ZERO;
            prev_dir  <= 1'b0;
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            laps      <= '0;
            step_err  <= 1'b0;
            seg       <= SEG_BLANK;
        end else begin
            // The history always tracks the bus. After a clear, the INIT
            // sample therefore starts from live data instead of stale data.
            prev_q    <= q_in;
            prev_dir  <= up_down;
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            seg       <= seg_dec;

            case (state)
                INIT: begin
                    state <= TRACK;
                end

                TRACK: begin
                    if (!step_ok) begin
                        // On the entry edge the dash is already shown.
                        // Laps and the pulses are not touched.
                        step_err <= 1'b1;
                        state    <= FAULT;
                        seg      <= SEG_DASH;
                    end else if (is_wrap_up) begin
                        wrap_up <= 1'b1;
                        if (laps != LAP_MAX) begin
                            laps <= laps + LAP_ONE;
                        end
                    end else if (is_wrap_down) begin
                        wrap_down <= 1'b1;
                        if (laps != LAP_MIN) begin
                            laps <= laps - LAP_ONE;
                        end
                    end
                end

                FAULT: begin
                    if (clear_fault) begin
                        // Leaving FAULT: show the live count again. Laps
                        // keep their value.
                        state    <= INIT;
                        step_err <= 1'b0;
                    end else begin
                        seg <= SEG_DASH;
                    end
                end

                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] q_in = 3'd0;
    logic       up_down = 1'b0;
    logic       clear_fault = 1'b0;
    logic       wrap_up;
    logic       wrap_down;
    logic [7:0] laps;
    logic       step_err;
    logic [6:0] seg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_monitor #(.CNT_W(3), .LAP_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .q_in        (q_in),
        .up_down     (up_down),
        .clear_fault (clear_fault),
        .wrap_up     (wrap_up),
        .wrap_down   (wrap_down),
        .laps        (laps),
        .step_err    (step_err),
        .seg         (seg)
    );

    // Present one sample on the falling edge and let it be clocked in.
    // The task returns 1 time unit after the rising edge, so the outputs can be read then.
    task automatic drive(input logic [2:0] q, input logic d);
        @(negedge clk);
        q_in    = q;
        up_down = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_fault = 1'b0;
        drive(3'd5, 1'b1);
        drive(3'd2, 1'b0);
        checks++; if (wrap_up !== 1'b0)   begin failures++; $display("FAIL reset_wrap_up got=%b exp=0", wrap_up); end
        checks++; if (wrap_down !== 1'b0) begin failures++; $display("FAIL reset_wrap_down got=%b exp=0", wrap_down); end
        checks++; if (laps !== 8'd0)      begin failures++; $display("FAIL reset_laps got=%0d exp=0", laps); end
        checks++; if (step_err !== 1'b0)  begin failures++; $display("FAIL reset_step_err got=%b exp=0", step_err); end
        checks++; if (seg !== 7'h00)      begin failures++; $display("FAIL reset_seg got=%h exp=00", seg); end
    endtask

    // The samples are 0 (INIT), then 1..7,0 twice, then 1,2,3. That is 20 samples.
    task automatic test_up_count;
        logic [2:0] q;
        logic       exp_wrap;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            q = 3'(i % 8);
            drive(q, 1'b1);
            exp_wrap = (q == 3'd0) && (i > 0);
            checks++; if (wrap_up !== exp_wrap) begin failures++; $display("FAIL up_wrap_up i=%0d got=%b exp=%b", i, wrap_up, exp_wrap); end
            checks++; if (step_err !== 1'b0)    begin failures++; $display("FAIL up_step_err i=%0d got=%b exp=0", i, step_err); end
            if (i == 7) begin
                checks++; if (seg !== 7'h07) begin failures++; $display("FAIL up_seg7 got=%h exp=07", seg); end
            end
        end
        checks++; if (seg !== 7'h4F)  begin failures++; $display("FAIL up_seg3 got=%h exp=4F", seg); end
        checks++; if (laps !== 8'd2)  begin failures++; $display("FAIL up_laps got=%0d exp=2", laps); end
    endtask

    // The last sample was 3 with dir=1. Next come 4 (reverse now), 3, 2, 1, 0, then 7, which is the wrap.
    task automatic test_down_wrap;
        drive(3'd4, 1'b0);
        drive(3'd3, 1'b0);
        drive(3'd2, 1'b0);
        drive(3'd1, 1'b0);
        drive(3'd0, 1'b0);
        checks++; if (wrap_down !== 1'b0 || wrap_up !== 1'b0) begin failures++; $display("FAIL dn_pre_wrap got=%b%b exp=00", wrap_up, wrap_down); end
        drive(3'd7, 1'b0);
        checks++; if (wrap_down !== 1'b1) begin failures++; $display("FAIL dn_wrap_down got=%b exp=1", wrap_down); end
        checks++; if (laps !== 8'd1)      begin failures++; $display("FAIL dn_laps got=%0d exp=1", laps); end
        checks++; if (seg !== 7'h07)      begin failures++; $display("FAIL dn_seg got=%h exp=07", seg); end
        drive(3'd6, 1'b0);
        checks++; if (wrap_down !== 1'b0) begin failures++; $display("FAIL dn_pulse_width got=%b exp=0", wrap_down); end
        checks++; if (step_err !== 1'b0)  begin failures++; $display("FAIL dn_step_err got=%b exp=0", step_err); end
    endtask

    // The last sample was 6 with dir=0. Then come 5 (now up), 6 (now down), 5.
    task automatic test_reverse;
        drive(3'd5, 1'b1);
        drive(3'd6, 1'b0);
        checks++; if (step_err !== 1'b0 || wrap_up !== 1'b0 || wrap_down !== 1'b0) begin failures++; $display("FAIL rev_mid got=%b%b%b exp=000", step_err, wrap_up, wrap_down); end
        drive(3'd5, 1'b0);
        checks++; if (step_err !== 1'b0 || wrap_up !== 1'b0 || wrap_down !== 1'b0) begin failures++; $display("FAIL rev_end got=%b%b%b exp=000", step_err, wrap_up, wrap_down); end
        checks++; if (seg !== 7'h6D) begin failures++; $display("FAIL rev_seg got=%h exp=6D", seg); end
        checks++; if (laps !== 8'd1) begin failures++; $display("FAIL rev_laps got=%0d exp=1", laps); end
    endtask

    task automatic test_fault;
        drive(3'd4, 1'b0);
        drive(3'd3, 1'b0);
        drive(3'd2, 1'b1);
        drive(3'd5, 1'b1);       // the expected value is 3
        checks++; if (step_err !== 1'b1) begin failures++; $display("FAIL flt_step_err got=%b exp=1", step_err); end
        checks++; if (seg !== 7'h40)     begin failures++; $display("FAIL flt_seg got=%h exp=40", seg); end
        checks++; if (laps !== 8'd1)     begin failures++; $display("FAIL flt_laps got=%0d exp=1", laps); end
        // A wrap while in FAULT must not be counted.
        drive(3'd6, 1'b1);
        drive(3'd7, 1'b1);
        drive(3'd0, 1'b1);
        checks++; if (wrap_up !== 1'b0)  begin failures++; $display("FAIL flt_no_wrap got=%b exp=0", wrap_up); end
        drive(3'd1, 1'b1);
        checks++; if (laps !== 8'd1)     begin failures++; $display("FAIL flt_laps_frozen got=%0d exp=1", laps); end
        checks++; if (step_err !== 1'b1 || seg !== 7'h40) begin failures++; $display("FAIL flt_hold got=%b/%h exp=1/40", step_err, seg); end
        clear_fault = 1'b1;
        drive(3'd2, 1'b1);
        clear_fault = 1'b0;
        checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL clr_step_err got=%b exp=0", step_err); end
        drive(3'd6, 1'b1);       // this INIT sample is not checked, although 2 -> 6 is not a legal step
        checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL clr_init_unchecked got=%b exp=0", step_err); end
        checks++; if (seg !== 7'h7D)     begin failures++; $display("FAIL clr_seg got=%h exp=7D", seg); end
        drive(3'd7, 1'b1);
        checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL clr_legal got=%b exp=0", step_err); end
        drive(3'd3, 1'b1);       // checking has resumed, and this step is illegal
        checks++; if (step_err !== 1'b1) begin failures++; $display("FAIL clr_resume got=%b exp=1", step_err); end
        checks++; if (laps !== 8'd1)     begin failures++; $display("FAIL clr_laps_kept got=%0d exp=1", laps); end
    endtask

    task automatic test_lap_saturation;
        rst = 1'b1;
        drive(3'd0, 1'b1);
        rst = 1'b0;
        drive(3'd0, 1'b1);       // INIT
        for (int n = 0; n < 127; n++) begin
            for (int v = 1; v <= 8; v++) drive(3'(v % 8), 1'b1);
        end
        checks++; if (laps !== 8'd127) begin failures++; $display("FAIL sat_up_reach got=%0d exp=127", laps); end
        for (int v = 1; v <= 8; v++) drive(3'(v % 8), 1'b1);
        checks++; if (wrap_up !== 1'b1) begin failures++; $display("FAIL sat_up_pulse got=%b exp=1", wrap_up); end
        checks++; if (laps !== 8'd127)  begin failures++; $display("FAIL sat_up_hold got=%0d exp=127", laps); end
        // Reverse at 0. The expected value is still 1 from the up direction, then the count runs down.
        drive(3'd1, 1'b0);
        for (int n = 0; n < 255; n++) begin
            drive(3'd0, 1'b0);
            for (int v = 7; v >= 1; v--) drive(3'(v), 1'b0);
        end
        checks++; if (laps !== 8'h80)    begin failures++; $display("FAIL sat_dn_reach got=%0d exp=-128", $signed(laps)); end
        drive(3'd0, 1'b0);
        drive(3'd7, 1'b0);
        checks++; if (wrap_down !== 1'b1) begin failures++; $display("FAIL sat_dn_pulse got=%b exp=1", wrap_down); end
        checks++; if (laps !== 8'h80)     begin failures++; $display("FAIL sat_dn_hold got=%0d exp=-128", $signed(laps)); end
        checks++; if (step_err !== 1'b0)  begin failures++; $display("FAIL sat_step_err got=%b exp=0", step_err); end
    endtask

    task automatic test_reset_in_fault;
        drive(3'd3, 1'b0);       // the expected value is 6
        checks++; if (step_err !== 1'b1) begin failures++; $display("FAIL rf_enter got=%b exp=1", step_err); end
        rst = 1'b1;
        clear_fault = 1'b1;
        drive(3'd2, 1'b1);
        rst = 1'b0;
        clear_fault = 1'b0;
        checks++; if (step_err !== 1'b0 || wrap_up !== 1'b0 || wrap_down !== 1'b0) begin failures++; $display("FAIL rf_flags got=%b%b%b exp=000", step_err, wrap_up, wrap_down); end
        checks++; if (laps !== 8'd0)  begin failures++; $display("FAIL rf_laps got=%0d exp=0", laps); end
        checks++; if (seg !== 7'h00)  begin failures++; $display("FAIL rf_seg got=%h exp=00", seg); end
        drive(3'd5, 1'b1);       // first sample after reset: not checked
        checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL rf_first_unchecked got=%b exp=0", step_err); end
        checks++; if (seg !== 7'h6D)     begin failures++; $display("FAIL rf_seg_live got=%h exp=6D", seg); end
        drive(3'd6, 1'b1);
        checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL rf_track got=%b exp=0", step_err); end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_reverse();
        test_fault();
        test_lap_saturation();
        test_reset_in_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Downstream consumer of the up/down counter.
- Samples the counter value and direction every clock and checks that each step is exactly +1 or -1, consistent with direction.
- Detects wrap-around events and keeps a signed, saturating lap count.
- Drives a registered 7-segment digit of the current count; a sticky fault is raised on any illegal step.

Parameters:
- CNT_W, 3, width of monitored count; legal 2..4.
- LAP_W, 8, width of signed lap counter.

Ports:
- clk  in  1  rising-edge clock, same clock as the counter.
- rst  in  1  synchronous, active-high reset.
- q_in  in  CNT_W  counter output.
- up_down  in  1  counter direction input (1 = up), tapped from the same net that feeds the counter.
- clear_fault  in  1  leaves FAULT; ignored in other states.
- wrap_up  out  1  one-cycle pulse on max->0 step while counting up.
- wrap_down  out  1  one-cycle pulse on 0->max step while counting down.
- laps  out  LAP_W  signed net lap count.
- step_err  out  1  sticky illegal-step flag.
- seg  out  7  segments {g,f,e,d,c,b,a}, active high.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high; all state changes on rising clk.
- Reset values: state=INIT; wrap_up=0, wrap_down=0, laps=0, step_err=0, seg=7'h00 (blank); prev_q=0, prev_dir=0.
- Every edge outside reset: prev_q<=q_in and prev_dir<=up_down, in all states.
- Expected value:
  - exp = prev_dir ? prev_q+1 : prev_q-1, modulo 2^CNT_W.
  - This models the counter: the value after edge n is derived from the direction sampled at edge n.
- INIT:
  - Captures the first sample, performs no check, and moves to TRACK.
  - Wrap pulses are 0.
- TRACK, q_in==exp:
  - If prev_dir=1, prev_q=max and q_in=0: wrap_up=1 next cycle, and laps+1 (saturates at +2^(LAP_W-1)-1).
  - If prev_dir=0, prev_q=0 and q_in=max: wrap_down=1 next cycle, and laps-1 (saturates at -2^(LAP_W-1)).
  - Otherwise pulses are 0 and laps is held.
- TRACK, q_in!=exp: step_err<=1, state<=FAULT, no lap or wrap update.
- FAULT:
  - No checking, no wrap pulses, laps frozen, step_err held 1.
  - clear_fault=1: state<=INIT and step_err<=0 on the same edge; laps is retained.
- Pulse width: wrap pulses are registered and last exactly one cycle; back-to-back wraps are impossible for CNT_W>=2.
- seg:
  - Registered decode of q_in, latency 1 cycle.
  - Hex codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - While in FAULT (or entering it this edge), seg=7'h40 ("-").
- Priority: rst over clear_fault over everything else.
- Reset mid-operation: everything returns to reset values at the next edge; the first post-reset sample is never checked.
- Direction change: a reversal (up->down) produces a legal step because exp uses prev_dir; no error.
- Arithmetic: exp computed in CNT_W bits with natural wrap; laps uses LAP_W-bit signed saturating add/sub.

Decomposition:
- Shared package count_mon_pkg: state enum {INIT, TRACK, FAULT}; segment constants SEG_BLANK=7'h00, SEG_DASH=7'h40; 16-entry hex-to-segment constant table.
- One sub-module, seg7_decode: purely combinational 4-bit hex to 7-segment. Instantiated once; the output register lives in count_monitor.

Test Plan:
- Reset, then up_down=1 with the counter free-running from 0 for 20 cycles -> step_err=0; wrap_up pulses exactly once per 8 steps, one cycle wide, on the cycle after q_in=0 is sampled; laps=2 after reaching 0 twice past 7; seg follows q_in one cycle late (3 -> 4F).
- From count 0 with up_down=0 -> q_in=7 sampled, wrap_down=1 for one cycle, laps decrements (2 -> 1).
- Reverse direction at q_in=5 (up then down) -> sequence 5,6,5 with no error and no wrap.
- Force q_in to jump 2->5 -> step_err=1 next cycle, state FAULT, seg=40, laps frozen; later wraps do not change laps. Pulse clear_fault -> step_err=0, state INIT; next sample is not checked, then checking resumes.
- Preload laps to 127 with up wraps, wrap again -> laps stays 127 and wrap_up still pulses. Same check at -128 for down wraps.
- Assert rst mid-count while in FAULT together with clear_fault -> next cycle all outputs at reset values, seg=00; the first post-reset sample is not checked.
